rr_sel_arbiter_16: RTL and testbench
====================================

// Module: rr_sel_arbiter_16
// PURPOSE
//   Round-robin arbiter that shares the 16:1 select path between 16 requesters.
//   Grants one requester at a time and drives the 4-bit mux select and a one-hot grant.
//   Holds each grant until release, requester drop, or hold timeout.
//   Sits in front of the 16x1 select datapath, replacing the static select input.
// PARAMETERS
//   N         16  number of requesters; fixed, matches the 16:1 datapath
//   SELW      4   select width, log2(N)
//   MAX_HOLD  8   maximum cycles a grant may be held; range 1..255
// PORTS
//   clk        in   1     rising-edge clock
//   rst        in   1     synchronous reset, active-high
//   req        in   16    request vector; bit k = requester k
//   done       in   1     granted requester releases the path this cycle
//   sel        out  4     mux select = index of granted requester
//   gnt        out  16    one-hot grant; all zero when no grant
//   gnt_valid  out  1     high while a grant is active (sel is meaningful)
//   timeout    out  1     one-cycle pulse when a grant is revoked by MAX_HOLD
// BEHAVIOUR
//   Reset (rst=1 at clk edge)
//     - All outputs registered and cleared next edge: sel=0, gnt=0, gnt_valid=0, timeout=0.
//     - State=IDLE, hold_cnt=0, last=15, so the first search starts at index 0.
//     - Reset mid-grant drops the grant in the same edge; no done or timeout is emitted.
//   States
//     IDLE
//       - If req != 0: pick the first set bit scanning last+1, last+2, ... mod 16.
//       - Next edge: load sel/gnt, gnt_valid=1, last=winner, hold_cnt=1, go to GRANT.
//       - If req == 0: stay in IDLE; outputs stay zero.
//     GRANT
//       - Release when any of these is true at an edge:
//         (a) done=1;
//         (b) req[sel]=0 (requester withdrew);
//         (c) hold_cnt==MAX_HOLD.
//       - On release: gnt=0, gnt_valid=0; go to IDLE.
//       - Case (c) with neither (a) nor (b): timeout=1 for exactly that one cycle.
//       - Otherwise: hold_cnt increments; sel and gnt are unchanged.
//   Timing
//     - Req-to-grant latency is 1 cycle from IDLE.
//     - Every release is followed by exactly one IDLE cycle (gnt_valid=0) before the next
//       grant, so back-to-back grants are spaced by one dead cycle.
//     - Maximum grant length is MAX_HOLD cycles.
//   Rules
//     - Changes to other req bits during GRANT are ignored; no preemption.
//     - done is ignored in IDLE.
//     - done together with hold expiry counts as a normal release: timeout=0.
//     - Pointer wrap: last=15 searches 0 next.
//     - A single persistent requester is re-granted after each IDLE gap.
//     - Fairness: any continuously requesting index is granted within
//       15*(MAX_HOLD+1) cycles.
//     - Invariants: gnt == (gnt_valid ? 1<<sel : 0); $onehot0(gnt) always.
// TESTING
//   T1 reset: hold rst=1 for 2 cycles with req=16'hFFFF -> gnt=0, sel=0, gnt_valid=0;
//      first grant after rst falls goes to index 0.
//   T2 rotation: req=16'h8001 held, done pulsed on each grant's 2nd cycle ->
//      grants alternate 0,15,0,15 with one idle cycle between.
//   T3 wrap: last=14, req=16'h4003 -> next grants 0, 1, 14 in order.
//   T4 timeout: req=16'h0010 held, done=0, MAX_HOLD=8 -> gnt=16'h0010 for 8 cycles,
//      timeout pulses once, 1 idle cycle, then index 4 is re-granted.
//   T5 withdraw / simultaneous: drop req[sel] mid-grant -> release next edge with timeout=0;
//      done=1 at hold_cnt==MAX_HOLD -> timeout=0.
//   T6 reset mid-grant: rst=1 during GRANT of index 7 -> gnt=0 next edge;
//      after reset the search restarts at index 0, not 8.

Source files
------------

// File: rtl/rr_sel_arbiter_16_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter
// that steers the shared 16:1 select path.
interface rr_sel_arbiter_16_if #(
    parameter int N    = 16,
    parameter int SELW = 4
);
    logic [N-1:0]    req;
    logic            done;
    logic [SELW-1:0] sel;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic            timeout;

    modport master (
        output req, done,
        input  sel, gnt, gnt_valid, timeout
    );

    modport slave (
        input  req, done,
        output sel, gnt, gnt_valid, timeout
    );
endinterface

// File: rtl/rr_sel_arbiter_16.sv
// Round-robin arbiter for the shared 16:1 select path: one grant at a time,
// held until done, requester drop, or MAX_HOLD expiry, then one idle cycle.
module rr_sel_arbiter_16 #(
    parameter int N        = 16,
    parameter int SELW     = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                rst,
    rr_sel_arbiter_16_if.slave  bus
);

    typedef enum logic [0:0] {IDLE, GRANT} state_t;

    state_t          state, state_nxt;
    logic [SELW-1:0] sel_q, sel_nxt;
    logic [N-1:0]    gnt_q, gnt_nxt;
    logic            vld_q, vld_nxt;
    logic            tmo_q, tmo_nxt;
    logic [7:0]      hold_cnt, hold_nxt;
    logic [SELW-1:0] last, last_nxt;

    logic            found;
    logic [SELW-1:0] winner;
    logic            rel_done, rel_drop, rel_exp;

    // Scan last+1, last+2, ... wrapping; the i==N step revisits last itself.
    function automatic logic [SELW:0] rr_pick(input logic [N-1:0] r,
                                              input logic [SELW-1:0] from);
        logic            hit;
        logic [SELW-1:0] idx;
        logic [SELW-1:0] pick;
        hit  = 1'b0;
        pick = '0;
        for (int i = 1; i <= N; i++) begin
            idx = from + SELW'(i);
            if (!hit && r[idx]) begin
                hit  = 1'b1;
                pick = idx;
            end
        end
        return {hit, pick};
    endfunction

    assign {found, winner} = rr_pick(bus.req, last);

    assign rel_done = bus.done;
    assign rel_drop = !bus.req[sel_q];
    assign rel_exp  = (hold_cnt == 8'(MAX_HOLD));

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_q;
        gnt_nxt   = gnt_q;
        vld_nxt   = vld_q;
        tmo_nxt   = 1'b0;
        hold_nxt  = hold_cnt;
        last_nxt  = last;
        case (state)
            IDLE: begin
                gnt_nxt = '0;
                vld_nxt = 1'b0;
                if (found) begin
                    sel_nxt   = winner;
                    gnt_nxt   = N'(1) << winner;
                    vld_nxt   = 1'b1;
                    last_nxt  = winner;
                    hold_nxt  = 8'd1;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (rel_done || rel_drop || rel_exp) begin
                    gnt_nxt   = '0;
                    vld_nxt   = 1'b0;
                    hold_nxt  = 8'd0;
                    state_nxt = IDLE;
                    // Only a pure expiry is reported; done or a drop at the limit is a normal release.
                    tmo_nxt   = rel_exp && !rel_done && !rel_drop;
                end else begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel_q    <= '0;
            gnt_q    <= '0;
            vld_q    <= 1'b0;
            tmo_q    <= 1'b0;
            hold_cnt <= 8'd0;
            last     <= SELW'(N - 1);
        end else begin
            state    <= state_nxt;
            sel_q    <= sel_nxt;
            gnt_q    <= gnt_nxt;
            vld_q    <= vld_nxt;
            tmo_q    <= tmo_nxt;
            hold_cnt <= hold_nxt;
            last     <= last_nxt;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = vld_q;
    assign bus.timeout   = tmo_q;

endmodule

// File: tb/tb_rr_sel_arbiter_16.sv
// Directed bench for rr_sel_arbiter_16: reset, rotation, wrap, timeout,
// withdraw/simultaneous release and reset during a grant.
module tb_rr_sel_arbiter_16;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    rr_sel_arbiter_16_if bus ();

    rr_sel_arbiter_16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Grant/select consistency on every settled cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (bus.gnt !== (bus.gnt_valid ? (16'h1 << bus.sel) : 16'h0)) begin
                failures++;
                $display("FAIL invariant gnt=%h sel=%0d valid=%b", bus.gnt, bus.sel, bus.gnt_valid);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus.req  = '0;
        bus.done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.req  = 16'hFFFF;
        bus.done = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.gnt !== 16'h0 || bus.sel !== 4'd0 || bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs gnt=%h sel=%0d valid=%b timeout=%b want 0", bus.gnt, bus.sel, bus.gnt_valid, bus.timeout);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.gnt !== 16'h0001 || bus.sel !== 4'd0 || bus.gnt_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_grant gnt=%h sel=%0d valid=%b want gnt=0001 sel=0", bus.gnt, bus.sel, bus.gnt_valid);
        end
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_rotation;
        logic [3:0] exp_idx [4];
        exp_idx = '{4'd0, 4'd15, 4'd0, 4'd15};
        do_reset();
        bus.req = 16'h8001;
        for (int g = 0; g < 4; g++) begin
            tick();
            checks++;
            if (bus.gnt !== (16'h1 << exp_idx[g]) || bus.sel !== exp_idx[g] || bus.gnt_valid !== 1'b1) begin
                failures++;
                $display("FAIL rotation_grant%0d gnt=%h sel=%0d want sel=%0d", g, bus.gnt, bus.sel, exp_idx[g]);
            end
            tick();
            checks++;
            if (bus.sel !== exp_idx[g] || bus.gnt_valid !== 1'b1) begin
                failures++;
                $display("FAIL rotation_hold%0d sel=%0d valid=%b want sel=%0d valid=1", g, bus.sel, bus.gnt_valid, exp_idx[g]);
            end
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            checks++;
            if (bus.gnt_valid !== 1'b0 || bus.gnt !== 16'h0 || bus.timeout !== 1'b0) begin
                failures++;
                $display("FAIL rotation_idle%0d valid=%b gnt=%h timeout=%b want idle", g, bus.gnt_valid, bus.gnt, bus.timeout);
            end
        end
        bus.req = '0;
        tick();
    endtask

    task automatic test_wrap;
        logic [3:0] exp_idx [3];
        exp_idx = '{4'd0, 4'd1, 4'd14};
        do_reset();
        bus.req = 16'h4000;
        tick();
        checks++;
        if (bus.sel !== 4'd14 || bus.gnt_valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap_setup sel=%0d valid=%b want sel=14", bus.sel, bus.gnt_valid);
        end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        bus.req  = 16'h4003;
        for (int g = 0; g < 3; g++) begin
            tick();
            checks++;
            if (bus.gnt !== (16'h1 << exp_idx[g]) || bus.sel !== exp_idx[g] || bus.gnt_valid !== 1'b1) begin
                failures++;
                $display("FAIL wrap_grant%0d gnt=%h sel=%0d want sel=%0d", g, bus.gnt, bus.sel, exp_idx[g]);
            end
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
        end
        bus.req = '0;
        tick();
    endtask

    task automatic test_timeout;
        int bad;
        do_reset();
        bus.req = 16'h0010;
        tick();
        bad = 0;
        for (int c = 1; c <= 8; c++) begin
            if (bus.gnt !== 16'h0010 || bus.timeout !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL timeout_hold bad_cycles=%0d want 0 (gnt=0010 for 8 cycles)", bad);
        end
        checks++;
        if (bus.gnt_valid !== 1'b0 || bus.gnt !== 16'h0 || bus.timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_pulse valid=%b gnt=%h timeout=%b want 0/0000/1", bus.gnt_valid, bus.gnt, bus.timeout);
        end
        tick();
        checks++;
        if (bus.gnt !== 16'h0010 || bus.sel !== 4'd4 || bus.gnt_valid !== 1'b1 || bus.timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_regrant gnt=%h sel=%0d timeout=%b want gnt=0010 sel=4 timeout=0", bus.gnt, bus.sel, bus.timeout);
        end
        bus.req = '0;
        tick();
        tick();
    endtask

    task automatic test_withdraw;
        do_reset();
        bus.req = 16'h0020;
        tick();
        tick();
        bus.req = 16'h0000;
        tick();
        checks++;
        if (bus.gnt_valid !== 1'b0 || bus.gnt !== 16'h0 || bus.timeout !== 1'b0) begin
            failures++;
            $display("FAIL withdraw_release valid=%b gnt=%h timeout=%b want 0/0000/0", bus.gnt_valid, bus.gnt, bus.timeout);
        end
        bus.req = 16'h0040;
        tick();
        for (int c = 0; c < 7; c++) tick();
        checks++;
        if (bus.gnt !== 16'h0040 || bus.gnt_valid !== 1'b1) begin
            failures++;
            $display("FAIL simul_at_limit gnt=%h valid=%b want 0040/1", bus.gnt, bus.gnt_valid);
        end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        checks++;
        if (bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin
            failures++;
            $display("FAIL simul_release valid=%b timeout=%b want 0/0", bus.gnt_valid, bus.timeout);
        end
        bus.req = '0;
        tick();
    endtask

    task automatic test_idle_done;
        do_reset();
        bus.done = 1'b1;
        tick();
        tick();
        bus.done = 1'b0;
        checks++;
        if (bus.gnt_valid !== 1'b0 || bus.gnt !== 16'h0 || bus.timeout !== 1'b0) begin
            failures++;
            $display("FAIL idle_done valid=%b gnt=%h timeout=%b want idle", bus.gnt_valid, bus.gnt, bus.timeout);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        bus.req = 16'h0080;
        tick();
        tick();
        bus.req = 16'h0080;
        tick();
        tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        tick();
        checks++;
        if (bus.sel !== 4'd7 || bus.gnt_valid !== 1'b1) begin
            failures++;
            $display("FAIL resetmid_setup sel=%0d valid=%b want 7/1", bus.sel, bus.gnt_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.gnt !== 16'h0 || bus.gnt_valid !== 1'b0 || bus.timeout !== 1'b0) begin
            failures++;
            $display("FAIL resetmid_drop gnt=%h valid=%b timeout=%b want 0000/0/0", bus.gnt, bus.gnt_valid, bus.timeout);
        end
        bus.req = 16'h0181;
        tick();
        checks++;
        if (bus.sel !== 4'd0 || bus.gnt !== 16'h0001) begin
            failures++;
            $display("FAIL resetmid_restart sel=%0d gnt=%h want sel=0 gnt=0001", bus.sel, bus.gnt);
        end
        bus.req = '0;
        tick();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.req  = '0;
        bus.done = 1'b0;
        test_reset();
        test_rotation();
        test_wrap();
        test_timeout();
        test_withdraw();
        test_idle_done();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
